// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command frame decoder.
package uart_cmd_pkg;

    localparam logic [7:0] C_START    = 8'h4B;
    localparam logic [7:0] C_TERM     = 8'h0D;
    localparam logic [7:0] C_ACK      = 8'h06;
    localparam logic [7:0] C_NAK      = 8'h15;

    // Command codes understood by the PWM register bank
    localparam logic [7:0] C_CMD_DUTY = 8'h00;
    localparam logic [7:0] C_CMD_EN   = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_TERM    = 3'd4,
        S_RESP    = 3'd5
    } state_e;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles, restarts on clear, flags expiry.
module uart_cmd_timeout #(
    parameter int unsigned g_TIMEOUT_CYC = 30000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (g_TIMEOUT_CYC > 1) ? $clog2(g_TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(g_TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A byte arriving in the expiry cycle wins over the timeout
    assign o_expire_c = i_en && !i_clr && (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_clr || !i_en || o_expire_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes K-framed commands from the UART receiver into a validated command
// strobe with parallel payload, and answers each finished frame with ACK/NAK.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned g_MAX_LEN     = 8,
    parameter int unsigned g_TIMEOUT_CYC = 30000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_vld,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_busy,
    output logic                   o_cmd_vld,
    output logic [7:0]             o_cmd,
    output logic [7:0]             o_len,
    output logic [8*g_MAX_LEN-1:0] o_payload,
    output logic                   o_frame_err,
    output logic                   o_timeout
);

    localparam int unsigned PAY_W = 8 * g_MAX_LEN;
    localparam int unsigned IDX_W = (g_MAX_LEN > 1) ? $clog2(g_MAX_LEN) : 1;
    localparam logic [7:0]  C_MAX_LEN_B = 8'(g_MAX_LEN);

    state_e             state_q, state_d;
    logic [7:0]         cmd_sh_q, cmd_sh_d;
    logic [7:0]         len_sh_q, len_sh_d;
    logic [PAY_W-1:0]   pay_sh_q, pay_sh_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         resp_q, resp_d;
    logic               sent_q, sent_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               cmd_vld_q, cmd_vld_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         len_q, len_d;
    logic [PAY_W-1:0]   payload_q, payload_d;
    logic               frame_err_q, frame_err_d;
    logic               timeout_q, timeout_d;
    logic               queue_resp_c;
    logic [7:0]         queue_byte_c;
    logic               wd_en_c;
    logic               wd_expire_c;

    assign wd_en_c = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_TERM);

    uart_cmd_timeout #(
        .g_TIMEOUT_CYC (g_TIMEOUT_CYC)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_rx_vld),
        .i_en       (wd_en_c),
        .o_expire_c (wd_expire_c)
    );

    always_comb begin
        state_d      = state_q;
        cmd_sh_d     = cmd_sh_q;
        len_sh_d     = len_sh_q;
        pay_sh_d     = pay_sh_q;
        idx_d        = idx_q;
        resp_d       = resp_q;
        sent_d       = sent_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        cmd_vld_d    = 1'b0;
        cmd_d        = cmd_q;
        len_d        = len_q;
        payload_d    = payload_q;
        frame_err_d  = 1'b0;
        timeout_d    = 1'b0;
        queue_resp_c = 1'b0;
        queue_byte_c = C_NAK;

        unique case (state_q)
            S_IDLE: begin
                if (i_rx_vld && (i_rx_data == C_START)) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (i_rx_vld) begin
                    cmd_sh_d = i_rx_data;
                    state_d  = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_vld) begin
                    if (i_rx_data >= C_MAX_LEN_B) begin
                        frame_err_d  = 1'b1;
                        queue_resp_c = 1'b1;
                    end else begin
                        len_sh_d = i_rx_data;
                        pay_sh_d = '0;
                        idx_d    = '0;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_vld) begin
                    for (int unsigned i = 0; i < g_MAX_LEN; i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            pay_sh_d[8*i +: 8] = i_rx_data;
                        end
                    end
                    if (8'(idx_q) == len_sh_q) begin
                        state_d = S_TERM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_TERM: begin
                if (i_rx_vld) begin
                    queue_resp_c = 1'b1;
                    if (i_rx_data == C_TERM) begin
                        cmd_d        = cmd_sh_q;
                        len_d        = len_sh_q;
                        payload_d    = pay_sh_q;
                        cmd_vld_d    = 1'b1;
                        queue_byte_c = C_ACK;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
            end
            S_RESP: begin
                // Stay here through the start pulse so RX bytes in that cycle are dropped
                if (sent_q) begin
                    state_d = S_IDLE;
                end else if (!i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = resp_q;
                    sent_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Launch the response right away when the transmitter is free
        if (queue_resp_c) begin
            resp_d  = queue_byte_c;
            sent_d  = !i_tx_busy;
            state_d = S_RESP;
            if (!i_tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = queue_byte_c;
            end
        end

        if (wd_expire_c) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cmd_sh_q    <= '0;
            len_sh_q    <= '0;
            pay_sh_q    <= '0;
            idx_q       <= '0;
            resp_q      <= '0;
            sent_q      <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            cmd_vld_q   <= 1'b0;
            cmd_q       <= '0;
            len_q       <= '0;
            payload_q   <= '0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_sh_q    <= cmd_sh_d;
            len_sh_q    <= len_sh_d;
            pay_sh_q    <= pay_sh_d;
            idx_q       <= idx_d;
            resp_q      <= resp_d;
            sent_q      <= sent_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            cmd_vld_q   <= cmd_vld_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            payload_q   <= payload_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_cmd_vld   = cmd_vld_q;
    assign o_cmd       = cmd_q;
    assign o_len       = len_q;
    assign o_payload   = payload_q;
    assign o_frame_err = frame_err_q;
    assign o_timeout   = timeout_q;

endmodule
